// File: rtl/spi_pkg.sv
// Shared types for the SPI slave data path: FSM states and CPOL/CPHA mode encoding.
package spi_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // Mode number is {CPOL, CPHA}, as in the usual SPI mode 0..3 naming.
   typedef enum logic [1:0] {
      MODE0 = 2'd0,
      MODE1 = 2'd1,
      MODE2 = 2'd2,
      MODE3 = 2'd3
   } spi_mode_t;

   function automatic spi_mode_t spi_mode(input logic cpol, input logic cpha);
      return spi_mode_t'({cpol, cpha});
   endfunction

   function automatic logic mode_cpol(input spi_mode_t m);
      return m[1];
   endfunction

   function automatic logic mode_cpha(input spi_mode_t m);
      return m[0];
   endfunction

endpackage

// File: rtl/spi_sync_2ff.sv
// Two-flop synchronizer for an asynchronous pin; reset value selects the safe idle level.
module spi_sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/spi_slave_byte_shifter.sv
// SPI slave word shifter: samples MOSI, shifts MISO from a one-entry TX hold register,
// frames words on SS and reports received words, underruns and aborted frames on clk.
//
//   state  | meaning
//   IDLE   | SS high; strobes ignored
//   ACTIVE | SS low; sampling MOSI and driving MISO
module spi_slave_byte_shifter
   import spi_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter logic                  CPOL       = 1'b0,
   parameter logic                  CPHA       = 1'b0,
   parameter logic                  MSB_FIRST  = 1'b1,
   parameter logic [DATA_WIDTH-1:0] TX_IDLE    = '1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  im_up_edge,
   input  logic                  im_down_edge,
   input  logic                  im_high_read,
   input  logic                  im_low_read,
   input  logic                  im_SS_spi,
   input  logic                  im_MOSI_spi,
   output logic                  om_MISO_spi,
   output logic                  om_MISO_oe,
   input  logic [DATA_WIDTH-1:0] im_tx_data,
   input  logic                  im_tx_valid,
   output logic                  om_tx_ready,
   output logic [DATA_WIDTH-1:0] om_rx_data,
   output logic                  om_rx_valid,
   output logic                  om_tx_underrun,
   output logic                  om_frame_abort,
   output logic                  om_busy
);

   localparam int              CW       = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);
   localparam spi_mode_t       MODE     = spi_mode(CPOL, CPHA);

   logic ss_sync, mosi_sync;

   spi_sync_2ff #(.RESET_VAL(1'b1)) u_sync_ss (
      .clk (clk),
      .rst (rst),
      .d   (im_SS_spi),
      .q   (ss_sync)
   );

   spi_sync_2ff #(.RESET_VAL(1'b0)) u_sync_mosi (
      .clk (clk),
      .rst (rst),
      .d   (im_MOSI_spi),
      .q   (mosi_sync)
   );

   logic lead_edge, trail_edge, lead_read, trail_read, sample, drive;

   assign lead_edge  = mode_cpol(MODE) ? im_down_edge : im_up_edge;
   assign trail_edge = mode_cpol(MODE) ? im_up_edge   : im_down_edge;
   assign lead_read  = mode_cpol(MODE) ? im_low_read  : im_high_read;
   assign trail_read = mode_cpol(MODE) ? im_high_read : im_low_read;
   assign sample     = mode_cpha(MODE) ? trail_read : lead_read;
   assign drive      = mode_cpha(MODE) ? lead_edge  : trail_edge;

   state_t                  state;
   logic [CW-1:0]           bit_cnt;
   logic [DATA_WIDTH-1:0]   rx_shift, tx_shift, hold_data;
   logic                    hold_full;
   logic                    word_done;

   logic                    word_start, shift_out, tx_write;
   logic [DATA_WIDTH-1:0]   start_word, next_rx;

   assign om_tx_ready = !hold_full;
   assign tx_write    = im_tx_valid && !hold_full;
   assign start_word  = hold_full ? hold_data : TX_IDLE;
   assign next_rx     = MSB_FIRST ? {rx_shift[DATA_WIDTH-2:0], mosi_sync}
                                  : {mosi_sync, rx_shift[DATA_WIDTH-1:1]};

   // CPHA=0 must present bit 0 before the first sampling edge, so it loads on SS fall
   // and on the drive edge that closes each word; CPHA=1 loads on a word's first drive edge.
   always_comb begin
      word_start = 1'b0;
      if (state == IDLE)
         word_start = !ss_sync && !mode_cpha(MODE);
      else if (!ss_sync && drive)
         word_start = mode_cpha(MODE) ? (bit_cnt == '0) : word_done;
   end

   assign shift_out = (state == ACTIVE) && !ss_sync && drive && !word_start;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         bit_cnt        <= '0;
         rx_shift       <= '0;
         tx_shift       <= '0;
         hold_data      <= '0;
         hold_full      <= 1'b0;
         word_done      <= 1'b0;
         om_MISO_spi    <= 1'b0;
         om_MISO_oe     <= 1'b0;
         om_busy        <= 1'b0;
         om_rx_data     <= '0;
         om_rx_valid    <= 1'b0;
         om_tx_underrun <= 1'b0;
         om_frame_abort <= 1'b0;
      end else begin
         om_rx_valid    <= 1'b0;
         om_tx_underrun <= 1'b0;
         om_frame_abort <= 1'b0;

         if (word_start) begin
            om_MISO_spi    <= MSB_FIRST ? start_word[DATA_WIDTH-1] : start_word[0];
            tx_shift       <= MSB_FIRST ? (start_word << 1) : (start_word >> 1);
            om_tx_underrun <= !hold_full;
         end else if (shift_out) begin
            om_MISO_spi <= MSB_FIRST ? tx_shift[DATA_WIDTH-1] : tx_shift[0];
            tx_shift    <= MSB_FIRST ? (tx_shift << 1) : (tx_shift >> 1);
         end

         // A write landing with an underrun start is kept for the following word.
         if (word_start && hold_full) begin
            hold_full <= 1'b0;
         end else if (tx_write) begin
            hold_full <= 1'b1;
            hold_data <= im_tx_data;
         end

         case (state)
            IDLE: begin
               if (!ss_sync) begin
                  state      <= ACTIVE;
                  om_busy    <= 1'b1;
                  om_MISO_oe <= 1'b1;
                  bit_cnt    <= '0;
                  word_done  <= 1'b0;
               end
            end
            ACTIVE: begin
               if (ss_sync) begin
                  state          <= IDLE;
                  om_busy        <= 1'b0;
                  om_MISO_oe     <= 1'b0;
                  om_MISO_spi    <= 1'b0;
                  bit_cnt        <= '0;
                  word_done      <= 1'b0;
                  om_frame_abort <= (bit_cnt != '0);
               end else begin
                  if (drive)
                     word_done <= 1'b0;
                  if (sample) begin
                     rx_shift <= next_rx;
                     if (bit_cnt == LAST_BIT) begin
                        bit_cnt     <= '0;
                        om_rx_data  <= next_rx;
                        om_rx_valid <= 1'b1;
                        word_done   <= 1'b1;
                     end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_byte_shifter.sv
// Bench for spi_slave_byte_shifter: a mode-0 and a mode-3 instance driven by an SPI master
// model, checked against a word-level model of the TX hold register and received frames.
module tb_spi_slave_byte_shifter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [1:0]  up, dn, hr, lr, ss, mosi, tx_valid;
   logic [15:0] tx_data;
   logic [1:0]  miso, oe, ready, rxv, und, abort, busy;
   logic [15:0] rxd;

   spi_slave_byte_shifter #(
      .DATA_WIDTH(8), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .TX_IDLE(8'hFF)
   ) u_mode0 (
      .clk(clk), .rst(rst),
      .im_up_edge(up[0]), .im_down_edge(dn[0]), .im_high_read(hr[0]), .im_low_read(lr[0]),
      .im_SS_spi(ss[0]), .im_MOSI_spi(mosi[0]),
      .om_MISO_spi(miso[0]), .om_MISO_oe(oe[0]),
      .im_tx_data(tx_data[7:0]), .im_tx_valid(tx_valid[0]), .om_tx_ready(ready[0]),
      .om_rx_data(rxd[7:0]), .om_rx_valid(rxv[0]), .om_tx_underrun(und[0]),
      .om_frame_abort(abort[0]), .om_busy(busy[0])
   );

   spi_slave_byte_shifter #(
      .DATA_WIDTH(8), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b1), .TX_IDLE(8'hFF)
   ) u_mode3 (
      .clk(clk), .rst(rst),
      .im_up_edge(up[1]), .im_down_edge(dn[1]), .im_high_read(hr[1]), .im_low_read(lr[1]),
      .im_SS_spi(ss[1]), .im_MOSI_spi(mosi[1]),
      .om_MISO_spi(miso[1]), .om_MISO_oe(oe[1]),
      .im_tx_data(tx_data[15:8]), .im_tx_valid(tx_valid[1]), .om_tx_ready(ready[1]),
      .om_rx_data(rxd[15:8]), .om_rx_valid(rxv[1]), .om_tx_underrun(und[1]),
      .om_frame_abort(abort[1]), .om_busy(busy[1])
   );

   int checks = 0;
   int errors = 0;

   // Word-level model: one-entry hold register, expected received words, event counters.
   bit   [1:0] hold_full_m;
   logic [7:0] hold_m [2];
   logic [7:0] exp_rx [$];
   int rx_exp[2], rx_seen[2], und_exp[2], und_seen[2], abort_exp[2], abort_seen[2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_start(input int m);
      if (hold_full_m[m]) begin
         hold_full_m[m] = 1'b0;
         return hold_m[m];
      end
      und_exp[m]++;
      return 8'hFF;
   endfunction

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rxv[k]) begin
            rx_seen[k]++;
            if (exp_rx.size() == 0) check("rx_queue", 32'(exp_rx.size()), 32'd1);
            else                    check("rx_data", 32'(rxd[k*8 +: 8]), 32'(exp_rx.pop_front()));
         end
         if (und[k])   und_seen[k]++;
         if (abort[k]) abort_seen[k]++;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // kind: 0 leading edge, 1 leading-phase read, 2 trailing edge, 3 trailing-phase read
   task automatic pulse(input int m, input int kind);
      bit cpol;
      cpol = (m == 1);
      case (kind)
         0: if (cpol) dn[m] = 1'b1; else up[m] = 1'b1;
         1: if (cpol) lr[m] = 1'b1; else hr[m] = 1'b1;
         2: if (cpol) up[m] = 1'b1; else dn[m] = 1'b1;
         default: if (cpol) hr[m] = 1'b1; else lr[m] = 1'b1;
      endcase
      @(posedge clk); #1;
      up[m] = 1'b0; dn[m] = 1'b0; hr[m] = 1'b0; lr[m] = 1'b0;
   endtask

   task automatic write_tx(input int m, input logic [7:0] d);
      check("tx_ready_pre", 32'(ready[m]), 32'(!hold_full_m[m]));
      tx_valid[m] = 1'b1;
      tx_data[m*8 +: 8] = d;
      @(posedge clk); #1;
      tx_valid[m] = 1'b0;
      if (!hold_full_m[m]) begin
         hold_full_m[m] = 1'b1;
         hold_m[m] = d;
      end
      check("tx_ready_post", 32'(ready[m]), 32'd0);
   endtask

   task automatic frame(input int m, input int nfull, input int npart,
                        input bit wr_mid, input logic [7:0] mid_d,
                        input bit wr_at_fall, input logic [7:0] fall_d,
                        input logic [7:0] w0, input bit use_w0);
      logic [7:0] ws [4];
      logic [7:0] cur, cap;
      int nwords, nb;
      nwords = nfull + ((npart > 0) ? 1 : 0);
      for (int i = 0; i < 4; i++) ws[i] = 8'($urandom_range(0, 255));
      if (use_w0) ws[0] = w0;
      for (int i = 0; i < nfull; i++) begin
         exp_rx.push_back(ws[i]);
         rx_exp[m]++;
      end
      if (npart > 0) abort_exp[m]++;
      cur = 8'h00;
      mosi[m] = ws[0][7];
      ss[m] = 1'b0;
      if (wr_at_fall) begin
         cycles(2);
         check("fall_ready", 32'(ready[m]), 32'(!hold_full_m[m]));
         tx_valid[m] = 1'b1;
         tx_data[m*8 +: 8] = fall_d;
         @(posedge clk); #1;
         tx_valid[m] = 1'b0;
         if (m == 0) cur = model_start(m);
         if (!hold_full_m[m]) begin
            hold_full_m[m] = 1'b1;
            hold_m[m] = fall_d;
         end
         cycles(1);
      end else begin
         cycles(4);
         if (m == 0) cur = model_start(m);
      end
      check("busy_on", 32'(busy[m]), 32'd1);
      check("oe_on", 32'(oe[m]), 32'd1);
      for (int j = 0; j < nwords; j++) begin
         nb = (j < nfull) ? 8 : npart;
         cap = 8'h00;
         for (int b = 0; b < nb; b++) begin
            if (m == 1 && b == 0) cur = model_start(m);
            pulse(m, 0);
            if (m == 1) mosi[m] = ws[j][7-b];
            cycles(3);
            if (m == 0) cap[7-b] = miso[m];
            pulse(m, 1);
            cycles(2);
            if (wr_mid && b == 3 && !hold_full_m[m]) write_tx(m, mid_d);
            if (m == 0 && nb == 8 && b == 7) begin
               check("miso_word", 32'(cap), 32'(cur));
               cur = model_start(m);
            end
            pulse(m, 2);
            if (m == 0) begin
               if (b < nb - 1)          mosi[m] = ws[j][6-b];
               else if (j + 1 < nwords) mosi[m] = ws[j+1][7];
            end
            cycles(3);
            if (m == 1) cap[7-b] = miso[m];
            pulse(m, 3);
            cycles(2);
         end
         if (m == 1 && nb == 8) check("miso_word", 32'(cap), 32'(cur));
      end
      ss[m] = 1'b1;
      cycles(6);
      check("busy_off", 32'(busy[m]), 32'd0);
      check("oe_off", 32'(oe[m]), 32'd0);
      check("rx_count", 32'(rx_seen[m]), 32'(rx_exp[m]));
      check("rx_pending", 32'(exp_rx.size()), 32'd0);
      check("underruns", 32'(und_seen[m]), 32'(und_exp[m]));
      check("aborts", 32'(abort_seen[m]), 32'(abort_exp[m]));
      check("tx_ready", 32'(ready[m]), 32'(!hold_full_m[m]));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int m, nfull, npart;
      logic [7:0] dummy;
      rst = 1'b1;
      up = '0; dn = '0; hr = '0; lr = '0;
      ss = 2'b11; mosi = '0; tx_valid = '0; tx_data = '0;
      hold_full_m = '0;
      hold_m[0] = '0; hold_m[1] = '0;
      cycles(3);
      check("reset_ready_in_rst", 32'(ready), 32'h3);
      rst = 1'b0;
      cycles(2);
      check("reset_miso", 32'(miso), 32'h0);
      check("reset_oe", 32'(oe), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_rx_data", 32'(rxd), 32'h0);
      check("reset_pulses", 32'({rxv, und, abort}), 32'h0);
      check("reset_ready", 32'(ready), 32'h3);

      // Mode 0: preloaded 3C out, A5 in.
      write_tx(0, 8'h3C);
      frame(0, 1, 0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hA5, 1'b1);
      // Mode 3: preloaded 81 out, 5A in, no underrun.
      write_tx(1, 8'h81);
      frame(1, 1, 0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h5A, 1'b1);
      check("mode3_no_underrun", 32'(und_seen[1]), 32'd0);
      // Back-to-back words: 11 preloaded, 22 written during the first word.
      write_tx(0, 8'h11);
      frame(0, 2, 0, 1'b1, 8'h22, 1'b0, 8'h00, 8'h00, 1'b0);
      write_tx(1, 8'h11);
      frame(1, 2, 0, 1'b1, 8'h22, 1'b0, 8'h00, 8'h00, 1'b0);
      // Empty hold at SS fall with a write in the same cycle.
      frame(0, 2, 0, 1'b0, 8'h00, 1'b1, 8'h6B, 8'h00, 1'b0);
      // Frames cut after 4 bits, then a full frame.
      frame(0, 0, 4, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      frame(0, 1, 0, 1'b0, 8'h00, 1'b0, 8'h00, 8'hC3, 1'b1);
      frame(1, 0, 4, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0);
      frame(1, 1, 0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h3C, 1'b1);

      // Reset in the middle of a mode-0 word with the hold register full.
      write_tx(0, 8'h77);
      mosi[0] = 1'b1;
      ss[0] = 1'b0;
      cycles(4);
      dummy = model_start(0);
      for (int b = 0; b < 3; b++) begin
         pulse(0, 0); cycles(2); pulse(0, 1); cycles(2);
         pulse(0, 2); cycles(2); pulse(0, 3); cycles(2);
      end
      write_tx(0, 8'h99);
      rst = 1'b1;
      ss = 2'b11;
      @(posedge clk); #1;
      check("midrst_miso", 32'(miso), 32'h0);
      check("midrst_oe", 32'(oe), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_rx_data", 32'(rxd), 32'h0);
      check("midrst_pulses", 32'({rxv, und, abort}), 32'h0);
      check("midrst_ready", 32'(ready), 32'h3);
      rst = 1'b0;
      hold_full_m = '0;
      cycles(6);
      check("midrst_rx_count", 32'(rx_seen[0]), 32'(rx_exp[0]));
      check("midrst_aborts", 32'(abort_seen[0]), 32'(abort_exp[0]));
      frame(0, 1, 0, 1'b0, 8'h00, 1'b0, 8'h00, 8'h96, 1'b1);

      for (int f = 0; f < 24; f++) begin
         m = $urandom_range(0, 1);
         if ($urandom_range(0, 1) == 1 && !hold_full_m[m])
            write_tx(m, 8'($urandom_range(0, 255)));
         nfull = $urandom_range(1, 3);
         npart = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
         frame(m, nfull, npart, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               1'b0, 8'h00, 8'h00, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
